ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, datapath width.
REQ-002 SHALL have parameter DEPTH, default 2, buffer entries; only 2 is supported.
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: ex_valid in 1, ex_ready out 1  upstream (EX/ALU) handshake.
REQ-006 SHALL have ports: ex_alu_result in WORD_SIZE, ex_store_data in WORD_SIZE, ex_pc in WORD_SIZE, ex_dest in 2  EX payload.
REQ-007 SHALL have ports: ex_mem_read, ex_mem_write, ex_reg_write, ex_is_wwd, ex_is_halt  in  1 each  control payload.
REQ-008 SHALL have ports: mem_valid out 1, mem_ready in 1  downstream (data cache / MEM) handshake.
REQ-009 SHALL have ports: mem_alu_result, mem_store_data, mem_pc out WORD_SIZE; mem_dest out 2; mem_mem_read, mem_mem_write, mem_reg_write, mem_is_wwd out 1 each  head-entry payload.
REQ-010 SHALL have ports: fwd_valid out 1, fwd_dest out 2, fwd_data out WORD_SIZE  forwarding tap to EX operand muxes.
REQ-011 SHALL have ports: occupancy out 2 (entries held); halted out 1 (sticky halt retired).

Function
REQ-012 SHALL be an in-order 2-entry FIFO between EX and MEM; payload = all ex_* inputs above.
REQ-013 SHALL accept an entry on a rising edge where ex_valid && ex_ready; SHALL retire head where mem_valid && mem_ready.
REQ-014 SHALL drive mem_valid = (occupancy != 0); mem_* payload = head entry, registered; no combinational path ex_* -> mem_*.
REQ-015 SHALL give latency of exactly 1 cycle: entry accepted at edge N is visible on mem_* after edge N when buffer was empty.
REQ-016 SHALL drive ex_ready = !reset && occupancy != 2 && !halt_pending; ex_ready SHALL NOT depend on mem_ready.
REQ-017 At occupancy 1 with simultaneous accept and retire, SHALL keep occupancy 1 and present the new entry as head next cycle.
REQ-018 At occupancy 2, SHALL accept nothing; a retire SHALL drop occupancy to 1 with the older second entry becoming head.
REQ-019 At occupancy 0, mem_ready SHALL be ignored; mem_* payload SHALL hold last value (don't-care for consumers).
REQ-020 SHALL hold mem_* stable while mem_valid && !mem_ready (stall from cache miss).
REQ-021 SHALL set halt_pending on accepting an entry with ex_is_halt=1; thereafter ex_ready=0 until reset.
REQ-022 SHALL set halted the cycle after the halt entry retires; halted SHALL stay 1 until reset.
REQ-023 SHALL drive fwd_valid = mem_valid && mem_reg_write && !mem_mem_read; fwd_dest = mem_dest; fwd_data = mem_alu_result.
REQ-024 SHALL store ex_* inputs unmodified (no arithmetic, no width change).
REQ-025 SHALL track occupancy as a 2-bit count, values 0..2 only; 3 is unreachable.

Reset
REQ-026 On a rising edge with reset=1, SHALL clear occupancy, halt_pending and halted to 0, and all stored payload to 0.
REQ-027 While reset=1, SHALL hold ex_ready=0, mem_valid=0 and fwd_valid=0.
REQ-028 Reset mid-stall SHALL discard all entries; no entry SHALL retire on the reset edge.
REQ-029 The first accept SHALL be possible on the first edge with reset=0.

Structure
REQ-030 Payload field widths and the control-bit layout SHALL reside in the shared CPU definitions package/header, alongside opcode and function constants.
REQ-031 SHALL instantiate one sub-module, pipe_fifo2, a generic 2-entry valid/ready FIFO parameterised by payload width; ex_mem_stage adds halt logic, forwarding tap and payload packing.

Verification
REQ-032 Bench SHALL apply reset, then push result 0x1234, dest 2, reg_write=1, mem_ready=1 and require mem_valid=1 and mem_alu_result=0x1234 one cycle later, fwd_valid=1, fwd_dest=2.
REQ-033 Bench SHALL apply mem_ready=0 and push 0x0001, 0x0002, 0x0003, and require ex_ready=0 after two accepts; mem_ready=1 then retires 0x0001, 0x0002 in order; 0x0003 accepted after.
REQ-034 Bench SHALL hold occupancy 1 with simultaneous push 0x00AA and pop, and require occupancy to stay 1 and head=0x00AA next cycle.
REQ-035 Bench SHALL push ex_mem_read=1, reg_write=1, and require fwd_valid=0 while it is head.
REQ-036 Bench SHALL push halt entry then another entry, and require ex_ready=0 after the halt accept, halted=1 one cycle after halt retires, and the second entry never accepted.
REQ-037 Bench SHALL fill both entries with mem_ready=0 and assert reset 1 cycle, and require occupancy=0, mem_valid=0, halted=0, and ex_ready=1 on the next cycle.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_pkg
// Shared CPU definitions used by the EX/MEM pipeline buffer:
//   - destination register field width
//   - control-bit layout carried alongside each EX/MEM entry
//   - opcode / function constants of the CPU's instruction set
//   - payload_width() helper that sizes the packed EX/MEM entry
// ---------------------------------------------------------------------------
package ex_mem_stage_pkg;

    // Register-file index width (4 architectural registers).
    localparam int DEST_W = 2;

    // Occupancy counter width for the 2-entry buffer (values 0..2).
    localparam int OCC_W = 2;

    // Control bits that travel with an entry. Packed MSB-first, so is_halt
    // lands in bit 0 of the packed control field.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic is_wwd;
        logic is_halt;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Opcode constants (4-bit primary opcode).
    localparam logic [3:0] OPC_ADI   = 4'd4;
    localparam logic [3:0] OPC_LWD   = 4'd7;
    localparam logic [3:0] OPC_SWD   = 4'd8;
    localparam logic [3:0] OPC_BNE   = 4'd0;
    localparam logic [3:0] OPC_JMP   = 4'd9;
    localparam logic [3:0] OPC_RTYPE = 4'd15;

    // Function constants for R-type instructions (6-bit function field).
    localparam logic [5:0] FUNC_ADD  = 6'd0;
    localparam logic [5:0] FUNC_SUB  = 6'd1;
    localparam logic [5:0] FUNC_WWD  = 6'd28;
    localparam logic [5:0] FUNC_HLT  = 6'd29;

    // Width of one packed entry: alu_result, store_data, pc, dest, control.
    function automatic int payload_width(input int word_size);
        return 3 * word_size + DEST_W + CTRL_W;
    endfunction

endpackage

// File: rtl/ex_mem_stage_pipe_fifo2.sv
// ---------------------------------------------------------------------------
// pipe_fifo2
// Generic 2-entry in-order valid/ready FIFO with a registered head.
//   clk      in   single clock, rising edge
//   reset    in   synchronous, active-high; empties the FIFO and clears data
//   i_valid  in   upstream offers i_data
//   o_ready  out  FIFO can take an entry (not full, not in reset)
//   i_data   in   WIDTH-bit entry
//   o_valid  out  head entry present (not in reset)
//   i_ready  in   downstream takes the head
//   o_data   out  head entry, straight from a register
//   o_count  out  entries held, 0..2
// o_ready never looks at i_ready, so a full FIFO does not accept even when the
// head retires on the same edge; that keeps the upstream ready path short.
// ---------------------------------------------------------------------------
module pipe_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_push;
    logic             w_pop;

    assign o_ready = !reset && (r_count != 2'd2);
    assign o_valid = !reset && (r_count != 2'd0);
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;
    assign o_data  = r_head;
    assign o_count = r_count;

    // NOTE: state is updated only with <= so every register in this block
    // samples the pre-edge values; mixing in = would make r_head/r_tail order
    // dependent on statement position.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
            // NOTE: the two data slots are cleared too; with only two entries
            // this is cheap and keeps a stale entry from showing on o_data.
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head  <= i_data;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        // Head leaves, newcomer takes its place directly.
                        r_head <= i_data;
                    end else if (w_push) begin
                        r_tail  <= i_data;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        // Head keeps its last value as a don't-care.
                        r_count <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_count <= 2'd1;
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
// EX -> MEM pipeline buffer: 2-entry in-order FIFO plus halt tracking and a
// forwarding tap taken from the head entry.
//   clk, reset              single clock; synchronous active-high reset
//   ex_valid / ex_ready     upstream handshake (ex_ready ignores mem_ready)
//   ex_alu_result, ex_store_data, ex_pc, ex_dest, ex_mem_read, ex_mem_write,
//   ex_reg_write, ex_is_wwd, ex_is_halt
//                           entry payload, stored unmodified
//   mem_valid / mem_ready   downstream handshake
//   mem_alu_result, mem_store_data, mem_pc, mem_dest, mem_mem_read,
//   mem_mem_write, mem_reg_write, mem_is_wwd
//                           registered head entry
//   fwd_valid/dest/data     head result usable by EX operand muxes
//   occupancy               entries held (0..2)
//   halted                  sticky: a halt entry has retired
// ---------------------------------------------------------------------------
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [WORD_SIZE-1:0] ex_alu_result,
    input  logic [WORD_SIZE-1:0] ex_store_data,
    input  logic [WORD_SIZE-1:0] ex_pc,
    input  logic [DEST_W-1:0]    ex_dest,
    input  logic                 ex_mem_read,
    input  logic                 ex_mem_write,
    input  logic                 ex_reg_write,
    input  logic                 ex_is_wwd,
    input  logic                 ex_is_halt,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [WORD_SIZE-1:0] mem_alu_result,
    output logic [WORD_SIZE-1:0] mem_store_data,
    output logic [WORD_SIZE-1:0] mem_pc,
    output logic [DEST_W-1:0]    mem_dest,
    output logic                 mem_mem_read,
    output logic                 mem_mem_write,
    output logic                 mem_reg_write,
    output logic                 mem_is_wwd,
    output logic                 fwd_valid,
    output logic [DEST_W-1:0]    fwd_dest,
    output logic [WORD_SIZE-1:0] fwd_data,
    output logic [OCC_W-1:0]     occupancy,
    output logic                 halted
);

    localparam int PAY_W = payload_width(WORD_SIZE);

    // The buffer is built around a fixed two-slot FIFO.
    if (DEPTH != 2) begin : g_depth_check
        $error("ex_mem_stage supports DEPTH == 2 only");
    end

    logic             r_halt_pending;
    logic             r_halted;
    ctrl_t            w_ex_ctrl;
    ctrl_t            w_head_ctrl;
    logic [PAY_W-1:0] w_ex_payload;
    logic [PAY_W-1:0] w_head_payload;
    logic             w_fifo_ready;
    logic             w_accept;
    logic             w_retire;

    assign w_ex_ctrl.mem_read  = ex_mem_read;
    assign w_ex_ctrl.mem_write = ex_mem_write;
    assign w_ex_ctrl.reg_write = ex_reg_write;
    assign w_ex_ctrl.is_wwd    = ex_is_wwd;
    assign w_ex_ctrl.is_halt   = ex_is_halt;

    assign w_ex_payload = {ex_alu_result, ex_store_data, ex_pc, ex_dest, w_ex_ctrl};

    // Once a halt is in flight nothing else may enter, so the FIFO only sees
    // ex_valid while no halt is pending.
    pipe_fifo2 #(
        .WIDTH (PAY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_valid (ex_valid && !r_halt_pending),
        .o_ready (w_fifo_ready),
        .i_data  (w_ex_payload),
        .o_valid (mem_valid),
        .i_ready (mem_ready),
        .o_data  (w_head_payload),
        .o_count (occupancy)
    );

    assign ex_ready = w_fifo_ready && !r_halt_pending;
    assign w_accept = ex_valid && ex_ready;
    assign w_retire = mem_valid && mem_ready;

    assign {mem_alu_result, mem_store_data, mem_pc, mem_dest, w_head_ctrl} = w_head_payload;
    assign mem_mem_read  = w_head_ctrl.mem_read;
    assign mem_mem_write = w_head_ctrl.mem_write;
    assign mem_reg_write = w_head_ctrl.reg_write;
    assign mem_is_wwd    = w_head_ctrl.is_wwd;

    // A load's alu_result is only the address, so it is not forwardable.
    assign fwd_valid = mem_valid && mem_reg_write && !mem_mem_read;
    assign fwd_dest  = mem_dest;
    assign fwd_data  = mem_alu_result;

    assign halted = r_halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_halt_pending <= 1'b0;
            r_halted       <= 1'b0;
        end else begin
            if (w_accept && ex_is_halt) begin
                r_halt_pending <= 1'b1;
            end
            if (w_retire && w_head_ctrl.is_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
// Directed vectors for ex_mem_stage. Each entry the bench expects to be
// accepted is pushed into a scoreboard queue when issued; a monitor pops and
// compares the head payload whenever the DUT retires an entry.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

    localparam int W = 16;

    logic          clk;
    logic          reset;
    logic          ex_valid;
    logic          ex_ready;
    logic [W-1:0]  ex_alu_result;
    logic [W-1:0]  ex_store_data;
    logic [W-1:0]  ex_pc;
    logic [1:0]    ex_dest;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_reg_write;
    logic          ex_is_wwd;
    logic          ex_is_halt;
    logic          mem_valid;
    logic          mem_ready;
    logic [W-1:0]  mem_alu_result;
    logic [W-1:0]  mem_store_data;
    logic [W-1:0]  mem_pc;
    logic [1:0]    mem_dest;
    logic          mem_mem_read;
    logic          mem_mem_write;
    logic          mem_reg_write;
    logic          mem_is_wwd;
    logic          fwd_valid;
    logic [1:0]    fwd_dest;
    logic [W-1:0]  fwd_data;
    logic [1:0]    occupancy;
    logic          halted;

    ex_mem_stage #(
        .WORD_SIZE (W),
        .DEPTH     (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_alu_result  (ex_alu_result),
        .ex_store_data  (ex_store_data),
        .ex_pc          (ex_pc),
        .ex_dest        (ex_dest),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_reg_write   (ex_reg_write),
        .ex_is_wwd      (ex_is_wwd),
        .ex_is_halt     (ex_is_halt),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_alu_result (mem_alu_result),
        .mem_store_data (mem_store_data),
        .mem_pc         (mem_pc),
        .mem_dest       (mem_dest),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_reg_write  (mem_reg_write),
        .mem_is_wwd     (mem_is_wwd),
        .fwd_valid      (fwd_valid),
        .fwd_dest       (fwd_dest),
        .fwd_data       (fwd_data),
        .occupancy      (occupancy),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] alu;
        logic [W-1:0] store;
        logic [W-1:0] pc;
        logic [1:0]   dest;
        logic         rd;
        logic         wr;
        logic         rw;
        logic         wwd;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Drive one EX entry. store_data and pc are derived from the result so
    // every field carries a distinct, checkable value.
    task automatic issue(input logic [W-1:0] alu, input logic [1:0] dest,
                         input logic rd, input logic wr, input logic rw,
                         input logic wwd, input logic hlt, input bit accepted);
        exp_t e;
        ex_valid      = 1'b1;
        ex_alu_result = alu;
        ex_store_data = alu + 16'd1;
        ex_pc         = alu ^ 16'h8000;
        ex_dest       = dest;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_reg_write  = rw;
        ex_is_wwd     = wwd;
        ex_is_halt    = hlt;
        if (accepted) begin
            e.alu   = alu;
            e.store = alu + 16'd1;
            e.pc    = alu ^ 16'h8000;
            e.dest  = dest;
            e.rd    = rd;
            e.wr    = wr;
            e.rw    = rw;
            e.wwd   = wwd;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        ex_valid      = 1'b0;
        ex_alu_result = '0;
        ex_store_data = '0;
        ex_pc         = '0;
        ex_dest       = '0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_reg_write  = 1'b0;
        ex_is_wwd     = 1'b0;
        ex_is_halt    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every retire must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && mem_valid && mem_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL retire_unexpected: got alu 0x%0h, want no retire", mem_alu_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ret_alu",   mem_alu_result, e.alu);
                check("ret_store", mem_store_data, e.store);
                check("ret_pc",    mem_pc,         e.pc);
                check("ret_dest",  mem_dest,       e.dest);
                check("ret_ctrl",  {mem_mem_read, mem_mem_write, mem_reg_write, mem_is_wwd},
                                   {e.rd, e.wr, e.rw, e.wwd});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        idle();
        @(negedge clk);
        check("rst_ex_ready",  ex_ready,  0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_fwd_valid", fwd_valid, 0);
        step();
        step();

        // Single entry, 1-cycle latency, forwarding tap; first accept on the
        // first edge after reset drops.
        reset = 1'b0;
        issue(16'h1234, 2'd2, 0, 0, 1, 0, 0, 1);
        mem_ready = 1'b1;
        @(negedge clk);
        check("init_occupancy", occupancy, 0);
        check("init_ex_ready",  ex_ready,  1);
        check("init_mem_valid", mem_valid, 0);
        check("init_halted",    halted,    0);
        step();
        idle();
        @(negedge clk);
        check("lat_mem_valid", mem_valid,      1);
        check("lat_alu",       mem_alu_result, 16'h1234);
        check("lat_fwd_valid", fwd_valid,      1);
        check("lat_fwd_dest",  fwd_dest,       2);
        check("lat_fwd_data",  fwd_data,       16'h1234);
        step();

        // Fill under stall, ordering, accept after drain.
        mem_ready = 1'b0;
        issue(16'h0001, 2'd1, 0, 0, 1, 0, 0, 1);
        @(negedge clk);
        check("fill1_ex_ready", ex_ready, 1);
        step();
        issue(16'h0002, 2'd0, 0, 0, 1, 1, 0, 1);
        @(negedge clk);
        check("fill2_ex_ready", ex_ready, 1);
        step();
        issue(16'h0003, 2'd3, 0, 1, 0, 0, 0, 1);
        @(negedge clk);
        check("full_ex_ready",  ex_ready,       0);
        check("full_occupancy", occupancy,      2);
        check("full_head",      mem_alu_result, 16'h0001);
        step();
        @(negedge clk);
        check("stall_hold_head", mem_alu_result, 16'h0001);
        check("stall_hold_pc",   mem_pc,         16'h8001);
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        check("full_retire_ex_ready", ex_ready, 0);
        step();
        @(negedge clk);
        check("after_pop_occupancy", occupancy, 1);
        check("after_pop_ex_ready",  ex_ready,  1);
        step();
        idle();
        @(negedge clk);
        check("third_occupancy", occupancy,      1);
        check("third_head",      mem_alu_result, 16'h0003);
        step();

        // Simultaneous push and pop at occupancy 1.
        mem_ready = 1'b0;
        issue(16'h0055, 2'd1, 0, 0, 1, 0, 0, 1);
        step();
        issue(16'h00AA, 2'd2, 0, 0, 1, 0, 0, 1);
        mem_ready = 1'b1;
        @(negedge clk);
        check("pp_before_occupancy", occupancy, 1);
        step();
        idle();
        mem_ready = 1'b0;
        @(negedge clk);
        check("pp_occupancy", occupancy,      1);
        check("pp_head",      mem_alu_result, 16'h00AA);
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        step();

        // Load at head suppresses forwarding; the following ALU entry does not.
        mem_ready = 1'b0;
        issue(16'h0BEE, 2'd1, 1, 0, 1, 0, 0, 1);
        step();
        issue(16'h0777, 2'd3, 0, 0, 1, 0, 0, 1);
        @(negedge clk);
        check("load_mem_valid", mem_valid, 1);
        check("load_fwd_valid", fwd_valid, 0);
        step();
        idle();
        mem_ready = 1'b1;
        @(negedge clk);
        check("load_pop_fwd_valid", fwd_valid, 0);
        step();
        @(negedge clk);
        check("alu_fwd_valid", fwd_valid, 1);
        check("alu_fwd_dest",  fwd_dest,  3);
        check("alu_fwd_data",  fwd_data,  16'h0777);
        step();

        // Halt entry blocks the stream; halted rises after it retires.
        mem_ready = 1'b0;
        issue(16'h0F0F, 2'd0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        check("halt_pre_ex_ready", ex_ready, 1);
        step();
        issue(16'h0BAD, 2'd2, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        check("halt_ex_ready", ex_ready, 0);
        check("halt_halted0",  halted,   0);
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        check("halt_retiring_halted", halted, 0);
        step();
        @(negedge clk);
        check("halted_set",       halted,    1);
        check("halted_occupancy", occupancy, 0);
        check("halted_ex_ready",  ex_ready,  0);
        check("halted_mem_valid", mem_valid, 0);
        step();
        step();
        step();
        @(negedge clk);
        check("halted_sticky",     halted,    1);
        check("halted_no_accept",  occupancy, 0);

        // Reset clears halt; then reset mid-stall discards a full buffer.
        idle();
        mem_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("unhalt_halted",   halted,   0);
        check("unhalt_ex_ready", ex_ready, 1);
        issue(16'h1111, 2'd1, 0, 0, 1, 0, 0, 0);
        step();
        issue(16'h2222, 2'd2, 0, 0, 1, 0, 0, 0);
        step();
        idle();
        @(negedge clk);
        check("prerst_occupancy", occupancy, 2);
        step();
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("inrst_mem_valid", mem_valid, 0);
        check("inrst_ex_ready",  ex_ready,  0);
        check("inrst_fwd_valid", fwd_valid, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("postrst_occupancy", occupancy,      0);
        check("postrst_mem_valid", mem_valid,      0);
        check("postrst_halted",    halted,         0);
        check("postrst_ex_ready",  ex_ready,       1);
        check("postrst_payload",   mem_alu_result, 0);

        // Normal traffic resumes after the reset.
        issue(16'h4321, 2'd3, 0, 0, 1, 0, 0, 1);
        step();
        idle();
        @(negedge clk);
        check("resume_head", mem_alu_result, 16'h4321);
        step();
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
